// File: rtl/dcache_slot_bank.sv
// Multi-slot scratch data cache shared by the regfile load/store stages and the DMA engine.
// Two registered read ports and two write ports; DMA wins same-slot write collisions.
module dcache_slot_bank #(
  parameter int DATA_W = 18,
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze,
  input  logic              ld_valid,
  input  logic [SLOT_W-1:0] ld_slot,
  output logic [DATA_W-1:0] ld_dat,
  output logic              ld_dat_valid,
  input  logic              st_valid,
  input  logic [SLOT_W-1:0] st_slot,
  input  logic [DATA_W-1:0] st_dat,
  input  logic              dma_rd_valid,
  input  logic [SLOT_W-1:0] dma_rd_slot,
  output logic [DATA_W-1:0] dma_rd_dat,
  output logic              dma_rd_dat_valid,
  input  logic              dma_wr_valid,
  input  logic [SLOT_W-1:0] dma_wr_slot,
  input  logic [DATA_W-1:0] dma_wr_dat,
  output logic [SLOTS-1:0]  slot_written,
  output logic [15:0]       wr_conflict_cnt
);
  // One extra bit so SLOTS == 2**SLOT_W is representable in range checks.
  localparam int IW = SLOT_W + 1;

  typedef logic [SLOTS-1:0][DATA_W-1:0] bank_t;

  bank_t             mem_q, mem_d, wr_next, rd_src;
  logic [DATA_W-1:0] ld_dat_q, ld_dat_d, dma_rd_dat_q, dma_rd_dat_d;
  logic              ld_dat_valid_q, ld_dat_valid_d;
  logic              dma_rd_dat_valid_q, dma_rd_dat_valid_d;
  logic [SLOTS-1:0]  slot_written_q, slot_written_d, written_next;
  logic [15:0]       wr_conflict_cnt_q, wr_conflict_cnt_d;
  logic              st_en, dw_en, collide;

  function automatic logic in_range(input logic [SLOT_W-1:0] s);
    return {1'b0, s} < IW'(SLOTS);
  endfunction

  // Out-of-range indices match no slot and fall through to zero.
  function automatic logic [DATA_W-1:0] rd_mux(input bank_t src, input logic [SLOT_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++)
      if ({1'b0, s} == IW'(i)) r = src[i];
    return r;
  endfunction

  always_comb begin
    st_en        = st_valid & in_range(st_slot);
    dw_en        = dma_wr_valid & in_range(dma_wr_slot);
    collide      = st_en & dw_en & (st_slot == dma_wr_slot);
    wr_next      = mem_q;
    written_next = slot_written_q;
    for (int i = 0; i < SLOTS; i++) begin
      if (dw_en && ({1'b0, dma_wr_slot} == IW'(i))) begin
        wr_next[i]      = dma_wr_dat;
        written_next[i] = 1'b1;
      end else if (st_en && ({1'b0, st_slot} == IW'(i))) begin
        wr_next[i]      = st_dat;
        written_next[i] = 1'b1;
      end
    end
    rd_src = (BYPASS != 0) ? wr_next : mem_q;

    mem_d              = mem_q;
    slot_written_d     = slot_written_q;
    wr_conflict_cnt_d  = wr_conflict_cnt_q;
    ld_dat_d           = ld_dat_q;
    ld_dat_valid_d     = ld_dat_valid_q;
    dma_rd_dat_d       = dma_rd_dat_q;
    dma_rd_dat_valid_d = dma_rd_dat_valid_q;
    if (!freeze) begin
      mem_d              = wr_next;
      slot_written_d     = written_next;
      if (collide && (wr_conflict_cnt_q != 16'hFFFF))
        wr_conflict_cnt_d = wr_conflict_cnt_q + 16'd1;
      ld_dat_valid_d     = ld_valid;
      dma_rd_dat_valid_d = dma_rd_valid;
      if (ld_valid)     ld_dat_d     = rd_mux(rd_src, ld_slot);
      if (dma_rd_valid) dma_rd_dat_d = rd_mux(rd_src, dma_rd_slot);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q              <= '0;
      slot_written_q     <= '0;
      wr_conflict_cnt_q  <= '0;
      ld_dat_q           <= '0;
      ld_dat_valid_q     <= 1'b0;
      dma_rd_dat_q       <= '0;
      dma_rd_dat_valid_q <= 1'b0;
    end else begin
      mem_q              <= mem_d;
      slot_written_q     <= slot_written_d;
      wr_conflict_cnt_q  <= wr_conflict_cnt_d;
      ld_dat_q           <= ld_dat_d;
      ld_dat_valid_q     <= ld_dat_valid_d;
      dma_rd_dat_q       <= dma_rd_dat_d;
      dma_rd_dat_valid_q <= dma_rd_dat_valid_d;
    end
  end

  assign ld_dat           = ld_dat_q;
  assign ld_dat_valid     = ld_dat_valid_q;
  assign dma_rd_dat       = dma_rd_dat_q;
  assign dma_rd_dat_valid = dma_rd_dat_valid_q;
  assign slot_written     = slot_written_q;
  assign wr_conflict_cnt  = wr_conflict_cnt_q;
endmodule

// File: tb/tb_dcache_slot_bank.sv
// Bench for dcache_slot_bank: three configurations (bypass, no bypass, 3 slots) share stimulus
// and are each checked against a per-instance reference model of the slot rules.
module tb_dcache_slot_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, freeze, ld_valid, st_valid, dma_rd_valid, dma_wr_valid;
  logic [1:0]  ld_slot, st_slot, dma_rd_slot, dma_wr_slot;
  logic [17:0] st_dat, dma_wr_dat;
  logic [17:0] ld_dat_o [3];
  logic [17:0] dr_dat_o [3];
  logic        ldv_o [3];
  logic        drv_o [3];
  logic [15:0] cnt_o [3];
  logic [3:0]  sw0, sw1;
  logic [2:0]  sw2;

  dcache_slot_bank #(.DATA_W(18), .SLOTS(4), .SLOT_W(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .freeze(freeze),
    .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_dat(ld_dat_o[0]), .ld_dat_valid(ldv_o[0]),
    .st_valid(st_valid), .st_slot(st_slot), .st_dat(st_dat),
    .dma_rd_valid(dma_rd_valid), .dma_rd_slot(dma_rd_slot), .dma_rd_dat(dr_dat_o[0]),
    .dma_rd_dat_valid(drv_o[0]),
    .dma_wr_valid(dma_wr_valid), .dma_wr_slot(dma_wr_slot), .dma_wr_dat(dma_wr_dat),
    .slot_written(sw0), .wr_conflict_cnt(cnt_o[0]));

  dcache_slot_bank #(.DATA_W(18), .SLOTS(4), .SLOT_W(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .freeze(freeze),
    .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_dat(ld_dat_o[1]), .ld_dat_valid(ldv_o[1]),
    .st_valid(st_valid), .st_slot(st_slot), .st_dat(st_dat),
    .dma_rd_valid(dma_rd_valid), .dma_rd_slot(dma_rd_slot), .dma_rd_dat(dr_dat_o[1]),
    .dma_rd_dat_valid(drv_o[1]),
    .dma_wr_valid(dma_wr_valid), .dma_wr_slot(dma_wr_slot), .dma_wr_dat(dma_wr_dat),
    .slot_written(sw1), .wr_conflict_cnt(cnt_o[1]));

  dcache_slot_bank #(.DATA_W(18), .SLOTS(3), .SLOT_W(2), .BYPASS(1)) u_s3 (
    .clk(clk), .reset(reset), .freeze(freeze),
    .ld_valid(ld_valid), .ld_slot(ld_slot), .ld_dat(ld_dat_o[2]), .ld_dat_valid(ldv_o[2]),
    .st_valid(st_valid), .st_slot(st_slot), .st_dat(st_dat),
    .dma_rd_valid(dma_rd_valid), .dma_rd_slot(dma_rd_slot), .dma_rd_dat(dr_dat_o[2]),
    .dma_rd_dat_valid(drv_o[2]),
    .dma_wr_valid(dma_wr_valid), .dma_wr_slot(dma_wr_slot), .dma_wr_dat(dma_wr_dat),
    .slot_written(sw2), .wr_conflict_cnt(cnt_o[2]));

  int          n_vec = 0;
  int          n_err = 0;
  int          slots_c [3] = '{4, 4, 3};
  int          byp_c   [3] = '{1, 0, 1};
  logic [17:0] m_mem [3][4];
  logic [3:0]  m_sw  [3];
  int          m_cnt [3];
  logic [17:0] m_ld  [3];
  logic [17:0] m_dr  [3];
  logic        m_ldv [3];
  logic        m_drv [3];

  function automatic logic [3:0] get_sw(input int k);
    case (k)
      0:       return sw0;
      1:       return sw1;
      default: return {1'b0, sw2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: spec rules applied with arrays; DMA write applied after store gives it priority.
  task automatic model_step();
    logic [17:0] nw [4];
    logic [17:0] view [4];
    bit st_ok, dw_ok;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int j = 0; j < 4; j++) m_mem[k][j] = '0;
        m_sw[k] = '0; m_cnt[k] = 0;
        m_ld[k] = '0; m_dr[k] = '0; m_ldv[k] = 1'b0; m_drv[k] = 1'b0;
      end else if (!freeze) begin
        for (int j = 0; j < 4; j++) nw[j] = m_mem[k][j];
        st_ok = st_valid && (int'(st_slot) < slots_c[k]);
        dw_ok = dma_wr_valid && (int'(dma_wr_slot) < slots_c[k]);
        if (st_ok) begin nw[st_slot] = st_dat; m_sw[k][st_slot] = 1'b1; end
        if (dw_ok) begin nw[dma_wr_slot] = dma_wr_dat; m_sw[k][dma_wr_slot] = 1'b1; end
        if (st_ok && dw_ok && st_slot == dma_wr_slot && m_cnt[k] < 65535) m_cnt[k]++;
        for (int j = 0; j < 4; j++) view[j] = (byp_c[k] != 0) ? nw[j] : m_mem[k][j];
        m_ldv[k] = ld_valid;
        m_drv[k] = dma_rd_valid;
        if (ld_valid)     m_ld[k] = (int'(ld_slot) < slots_c[k]) ? view[ld_slot] : '0;
        if (dma_rd_valid) m_dr[k] = (int'(dma_rd_slot) < slots_c[k]) ? view[dma_rd_slot] : '0;
        for (int j = 0; j < 4; j++) m_mem[k][j] = nw[j];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ld_dat[%0d]", k), 32'(ld_dat_o[k]), 32'(m_ld[k]));
      chk($sformatf("ld_dat_valid[%0d]", k), 32'(ldv_o[k]), 32'(m_ldv[k]));
      chk($sformatf("dma_rd_dat[%0d]", k), 32'(dr_dat_o[k]), 32'(m_dr[k]));
      chk($sformatf("dma_rd_dat_valid[%0d]", k), 32'(drv_o[k]), 32'(m_drv[k]));
      chk($sformatf("slot_written[%0d]", k), 32'(get_sw(k)), 32'(m_sw[k]));
      chk($sformatf("wr_conflict_cnt[%0d]", k), 32'(cnt_o[k]), 32'(m_cnt[k]));
    end
  endtask

  task automatic idle();
    reset = 1'b0; freeze = 1'b0;
    ld_valid = 1'b0; st_valid = 1'b0; dma_rd_valid = 1'b0; dma_wr_valid = 1'b0;
  endtask

  task automatic step(input bit do_chk);
    @(posedge clk);
    model_step();
    #1;
    if (do_chk) compare_all();
  endtask

  initial begin
    idle();
    ld_slot = '0; st_slot = '0; dma_rd_slot = '0; dma_wr_slot = '0;
    st_dat = '0; dma_wr_dat = '0;
    reset = 1'b1;
    step(1'b1);

    // Load after reset returns zero with valid.
    idle(); ld_valid = 1'b1; ld_slot = 2'd1;
    step(1'b1);
    chk("plan1_ld_dat", 32'(ld_dat_o[0]), 32'h0);
    chk("plan1_ld_valid", 32'(ldv_o[0]), 32'h1);
    chk("plan1_sw", 32'(sw0), 32'h0);
    chk("plan1_cnt", 32'(cnt_o[0]), 32'h0);

    // Store then read on both ports.
    idle(); st_valid = 1'b1; st_slot = 2'd2; st_dat = 18'h2A5A;
    step(1'b1);
    idle(); ld_valid = 1'b1; ld_slot = 2'd2; dma_rd_valid = 1'b1; dma_rd_slot = 2'd2;
    step(1'b1);
    chk("plan2_ld_dat", 32'(ld_dat_o[0]), 32'h2A5A);
    chk("plan2_dma_dat", 32'(dr_dat_o[0]), 32'h2A5A);
    chk("plan2_sw", 32'(sw0), 32'h4);

    // Write collision: DMA wins and the counter counts.
    idle(); st_valid = 1'b1; st_slot = 2'd3; st_dat = 18'h00011;
    dma_wr_valid = 1'b1; dma_wr_slot = 2'd3; dma_wr_dat = 18'h3FFFF;
    step(1'b1);
    chk("plan3_cnt1", 32'(cnt_o[0]), 32'h1);
    idle(); ld_valid = 1'b1; ld_slot = 2'd3;
    step(1'b1);
    chk("plan3_dma_wins", 32'(ld_dat_o[0]), 32'h3FFFF);
    idle(); st_valid = 1'b1; st_slot = 2'd3; st_dat = 18'h00011;
    dma_wr_valid = 1'b1; dma_wr_slot = 2'd3; dma_wr_dat = 18'h3FFFF;
    for (int i = 0; i < 70000; i++) step(1'b0);
    step(1'b1);
    chk("plan3_saturate", 32'(cnt_o[0]), 32'hFFFF);

    // Bypass vs pre-write value.
    idle(); st_valid = 1'b1; st_slot = 2'd0; st_dat = 18'h00456;
    step(1'b1);
    idle(); st_valid = 1'b1; st_slot = 2'd0; st_dat = 18'h00123; ld_valid = 1'b1; ld_slot = 2'd0;
    step(1'b1);
    chk("plan4_bypass", 32'(ld_dat_o[0]), 32'h00123);
    chk("plan4_nobypass", 32'(ld_dat_o[1]), 32'h00456);

    // Freeze drops requests and holds outputs.
    idle(); freeze = 1'b1; st_valid = 1'b1; st_slot = 2'd1; st_dat = 18'h00077;
    ld_valid = 1'b1; ld_slot = 2'd1;
    step(1'b1);
    chk("plan5_hold_dat", 32'(ld_dat_o[0]), 32'h00123);
    chk("plan5_hold_valid", 32'(ldv_o[0]), 32'h1);
    idle(); ld_valid = 1'b1; ld_slot = 2'd1;
    step(1'b1);
    chk("plan5_slot1_unchanged", 32'(ld_dat_o[0]), 32'h0);
    idle(); freeze = 1'b1; reset = 1'b1;
    step(1'b1);
    chk("plan5_rst_cnt", 32'(cnt_o[0]), 32'h0);
    chk("plan5_rst_sw", 32'(sw0), 32'h0);

    // Out-of-range slot on the 3-slot instance.
    idle(); st_valid = 1'b1; st_slot = 2'd0; st_dat = 18'h1BEEF;
    step(1'b1);
    idle(); ld_valid = 1'b1; ld_slot = 2'd0;
    step(1'b1);
    idle(); st_valid = 1'b1; st_slot = 2'd3; st_dat = 18'h0AAAA;
    dma_wr_valid = 1'b1; dma_wr_slot = 2'd3; dma_wr_dat = 18'h05555;
    step(1'b1);
    chk("plan6_sw", 32'(sw2), 32'h1);
    chk("plan6_cnt", 32'(cnt_o[2]), 32'h0);
    idle(); ld_valid = 1'b1; ld_slot = 2'd3; dma_rd_valid = 1'b1; dma_rd_slot = 2'd3;
    step(1'b1);
    chk("plan6_oor_dat", 32'(ld_dat_o[2]), 32'h0);
    chk("plan6_oor_valid", 32'(drv_o[2]), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(63) == 0);
      freeze       = ($urandom_range(7) == 0);
      ld_valid     = $urandom_range(1);
      st_valid     = $urandom_range(1);
      dma_rd_valid = $urandom_range(1);
      dma_wr_valid = $urandom_range(1);
      ld_slot      = 2'($urandom_range(3));
      st_slot      = 2'($urandom_range(3));
      dma_rd_slot  = 2'($urandom_range(3));
      dma_wr_slot  = ($urandom_range(3) == 0) ? st_slot : 2'($urandom_range(3));
      if ($urandom_range(3) == 0) ld_slot = st_slot;
      st_dat       = 18'($urandom);
      dma_wr_dat   = 18'($urandom);
      step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_slot_bank.md
Name: dcache_slot_bank

Overview:
- Parametrised multi-slot scratch data cache: SLOTS independent registers of DATA_W bits each.
- Serves two read ports: regfile load and DMA read. Serves two write ports: regfile store and DMA write.
- Sits between the regfile load/store pipeline stages and the DMA engine.
- Extends the single-tile slot scheme with configurable slot count and width, deterministic write-collision priority, optional read-after-write bypass, per-slot written flags and a collision counter.

Parameters:
- DATA_W, 18, bits per slot.
- SLOTS, 4, number of slots; legal range 1..2**SLOT_W.
- SLOT_W, 2, width of slot index ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to a read of the same slot; when 0 the read returns the pre-write value.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; overrides freeze.
- freeze  in  1  pipeline stall; while high all state and outputs hold.
- ld_valid  in  1  regfile load request.
- ld_slot  in  SLOT_W  load slot index.
- ld_dat  out  DATA_W  load data, registered.
- ld_dat_valid  out  1  ld_dat is valid this cycle.
- st_valid  in  1  regfile store request.
- st_slot  in  SLOT_W  store slot index.
- st_dat  in  DATA_W  store data.
- dma_rd_valid  in  1  DMA read request.
- dma_rd_slot  in  SLOT_W  DMA read slot index.
- dma_rd_dat  out  DATA_W  DMA read data, registered.
- dma_rd_dat_valid  out  1  dma_rd_dat is valid this cycle.
- dma_wr_valid  in  1  DMA write request.
- dma_wr_slot  in  SLOT_W  DMA write slot index.
- dma_wr_dat  in  DATA_W  DMA write data.
- slot_written  out  SLOTS  sticky flag per slot, set by any committed write.
- wr_conflict_cnt  out  16  saturating count of write collisions.

Behaviour:
- Reset (clk edge with reset=1): all slots, ld_dat, dma_rd_dat, both *_valid outputs, slot_written and wr_conflict_cnt go to 0. Reset takes effect regardless of freeze.
- Freeze=1, reset=0: no write commits, no read registers, counter and flags unchanged, outputs hold their previous values. Requests presented during freeze are dropped, not queued.
- Read latency is 1 cycle.
  - Request with valid=1 at edge N: data appears after edge N, and *_dat_valid=1 for exactly that cycle.
  - Cycles with valid=0 and freeze=0: *_dat_valid=0 and *_dat holds its last value.
- Read of an out-of-range slot (index >= SLOTS): *_dat_valid=1, *_dat=0.
- Writes commit at the edge where valid=1 and freeze=0. Out-of-range writes are ignored: no slot change, no flag set, no conflict count.
- Write collision: st_valid and dma_wr_valid both 1, st_slot==dma_wr_slot, slot in range.
  - DMA data is stored.
  - wr_conflict_cnt increments by 1, saturating at 16'hFFFF.
- Writes to different slots in the same cycle both commit.
- Bypass: read and write to the same slot at the same edge.
  - BYPASS=1: read returns the committed write data, with DMA priority applied under collision.
  - BYPASS=0: read returns the value before the write.
- Both read ports may address any slots, including the same slot, every cycle with no conflict.
- slot_written[i] is set on the edge a write to slot i commits. It clears only on reset.
- All arithmetic is unsigned. Slot indices compare at full SLOT_W width.

Test Plan:
1. Reset, then load slot 1 -> next cycle ld_dat=0, ld_dat_valid=1; slot_written=4'b0000, wr_conflict_cnt=0.
2. Store 18'h2A5A to slot 2; next cycle load slot 2 and DMA-read slot 2 -> both ports return 18'h2A5A; slot_written=4'b0100.
3. In one cycle, store 18'h00011 and DMA-write 18'h3FFFF, both to slot 3 -> slot 3=18'h3FFFF, wr_conflict_cnt=1. Repeat 70000 times -> counter saturates at 16'hFFFF.
4. BYPASS=1: store 18'h00123 to slot 0 while loading slot 0 -> ld_dat=18'h00123. BYPASS=0 with the same stimulus -> ld_dat equals the prior value.
5. freeze=1 while store 18'h00077 to slot 1 and load slot 1 are presented -> slot 1 unchanged, ld_dat and ld_dat_valid hold. Assert reset together with freeze -> everything reads 0.
6. SLOTS=3, SLOT_W=2: write to slot 3 -> slot_written=3'b000, nothing changes; read slot 3 -> dat=0, dat_valid=1.
